mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single RAMHelper memory port between the instruction-fetch requester (IF) and the
//   load/store requester (D). One transaction is outstanding at a time.
//   Fixed priority to D, with a starvation guard that forces an IF grant.
//   Sits between if_stage / mem stage and the RAMHelper instance; all address-to-index conversion lives here.
// PARAMETERS
//   MEM_BASE  64'h8000_0000  byte address mapped to memory index 0 (matches `PC_START)
//   MAX_WAIT  4              consecutive IF denials before IF is forced to win arbitration
// PORTS
//   clk            in   1   clock
//   rst            in   1   reset, synchronous, active-high
//   if_req_valid   in   1   IF request present
//   if_req_addr    in   64  IF byte address (4-byte aligned)
//   if_req_ready   out  1   IF request accepted this cycle when valid&ready
//   if_resp_valid  out  1   IF response, 1-cycle pulse
//   if_resp_inst   out  32  fetched instruction
//   d_req_valid    in   1   D request present
//   d_req_addr     in   64  D byte address (8-byte aligned word access)
//   d_req_wen      in   1   1 = write, 0 = read
//   d_req_wdata    in   64  write data
//   d_req_wmask    in   64  per-bit write mask
//   d_req_ready    out  1   D request accepted this cycle when valid&ready
//   d_resp_valid   out  1   D response, 1-cycle pulse (reads and writes)
//   d_resp_rdata   out  64  read data; 0 for writes
//   mem_en         out  1   memory enable, ISSUE cycle only
//   mem_ridx       out  64  read index  = (addr - MEM_BASE) >> 3
//   mem_rdata      in   64  read data, valid the cycle after mem_en
//   mem_widx       out  64  write index = (addr - MEM_BASE) >> 3
//   mem_wdata      out  64  write data
//   mem_wmask      out  64  write mask
//   mem_wen        out  1   write enable, ISSUE cycle only
// BEHAVIOUR
//   - FSM: IDLE -> ISSUE -> RESP -> IDLE. Exactly one request per pass, so throughput is 1 per 3 cycles.
//   - IDLE:
//       - grant_d  = d_req_valid & ~(if_req_valid & wait_cnt==MAX_WAIT).
//       - grant_if = if_req_valid & ~grant_d.
//       - ready outputs are combinational: {if,d}_req_ready = (state==IDLE) & grant_x. They are 0 in every other state.
//       - On a handshake: latch owner, addr, wen, wdata and wmask, then go to ISSUE.
//   - wait_cnt (3-bit, saturates at MAX_WAIT):
//       - +1 in an IDLE cycle where if_req_valid & grant_d.
//       - Cleared on an IF grant or when if_req_valid is 0 in IDLE.
//   - ISSUE:
//       - mem_en=1; ridx and widx are taken from the latched addr; mem_wen = latched wen.
//       - wdata and wmask are driven only when mem_wen=1, otherwise 0.
//   - RESP: exactly one of if_resp_valid / d_resp_valid is 1, selected by the latched owner. The requester cannot stall it.
//       - if_resp_inst = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
//       - d_resp_rdata = mem_rdata for reads, 64'h0 for writes.
//   - Latency: handshake in cycle T, memory access in T+1, response in T+2, next accept possible in T+3.
//   - Responses return in acceptance order; with one outstanding request there is no reordering.
//   - Outputs outside RESP: resp valids are 0 and resp data is 0. Outputs outside ISSUE: mem_* are all 0.
//   - Index arithmetic is 64-bit unsigned. An address below MEM_BASE wraps and is not checked; the caller must stay in range.
//   - Simultaneous IF+D in IDLE: D wins unless wait_cnt==MAX_WAIT, in which case IF wins.
//   - Reset:
//       - Values: state=IDLE, wait_cnt=0, latched regs=0, all outputs 0. Readies become combinational from IDLE in the next cycle.
//       - rst during ISSUE or RESP drops the transaction: no response is given, and a write already issued in ISSUE stays in memory.
// TESTING
//   1. Single IF read, addr=MEM_BASE+4, mem word 64'h1111_2222_3333_4444 -> if_req_ready at T, mem_en/ridx=0 at T+1, if_resp_inst=32'h1111_2222 at T+2.
//   2. D write to MEM_BASE+8, wdata=64'hDEAD_BEEF_0000_0001, mask all-ones, then a D read of the same address ->
//      mem_wen with widx=1 in ISSUE, d_resp_rdata=0; the read returns 64'hDEAD_BEEF_0000_0001.
//   3. IF and D both valid continuously -> D granted 4 times with wait_cnt 1..4, 5th grant goes to IF, wait_cnt returns to 0, pattern repeats.
//   4. Simultaneous request with wait_cnt<MAX_WAIT -> only d_req_ready=1; if_req_ready stays 0 until the next IDLE.
//   5. rst asserted in the ISSUE cycle of an IF read -> no if_resp_valid, FSM in IDLE next cycle, new request accepted immediately.
//   6. Back-to-back D reads -> accepts spaced exactly 3 cycles apart; ready=0 throughout ISSUE and RESP.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every signal between the two requesters (instruction fetch and
//   load/store), the arbiter and the single-ported RAMHelper memory.
//
//   Requester side:
//     if_req_valid/if_req_addr/if_req_ready    IF request handshake
//     if_resp_valid/if_resp_inst               IF response (1-cycle pulse)
//     d_req_valid/d_req_addr/d_req_wen/
//     d_req_wdata/d_req_wmask/d_req_ready      D request handshake
//     d_resp_valid/d_resp_rdata                D response (1-cycle pulse)
//   Memory side:
//     mem_en/mem_ridx/mem_widx/mem_wdata/
//     mem_wmask/mem_wen                        issued by the arbiter
//     mem_rdata                                returned by memory one cycle later
//
//   Modports:
//     slave  - the arbiter
//     master - the surroundings: both requesters plus the memory instance
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // IF requester
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;

  // Load/store requester
  logic        d_req_valid;
  logic [63:0] d_req_addr;
  logic        d_req_wen;
  logic [63:0] d_req_wdata;
  logic [63:0] d_req_wmask;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;

  // Memory port
  logic        mem_en;
  logic [63:0] mem_ridx;
  logic [63:0] mem_rdata;
  logic [63:0] mem_widx;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic        mem_wen;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_inst,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output mem_en, mem_ridx, mem_widx, mem_wdata, mem_wmask, mem_wen,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_inst,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  mem_en, mem_ridx, mem_widx, mem_wdata, mem_wmask, mem_wen,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single RAMHelper port between instruction fetch (IF) and
//   load/store (D). Exactly one transaction is in flight: a request is accepted
//   in IDLE, issued to memory in ISSUE and answered in RESP, so the port handles
//   at most one request every three cycles.
//
//   Arbitration gives D fixed priority. A saturating counter tracks how many
//   times in a row IF was waiting while D won; once it reaches MAX_WAIT, IF wins
//   the next simultaneous request.
//
//   Byte addresses are turned into 64-bit word indices here:
//     index = (addr - MEM_BASE) >> 3  (unsigned, wraps below MEM_BASE)
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset; drops any transaction in flight
//            (a write already issued to memory is not undone)
//     bus  - mem_port_arbiter_if.slave, requester and memory signals
//
//   Parameters:
//     MEM_BASE - byte address mapped to memory index 0
//     MAX_WAIT - consecutive IF denials before IF is forced to win
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,    state_d;
  owner_e      owner_q,    owner_d;
  logic [63:0] addr_q,     addr_d;
  logic        wen_q,      wen_d;
  logic [63:0] wdata_q,    wdata_d;
  logic [63:0] wmask_q,    wmask_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;

  logic        in_idle;
  logic        d_grant;
  logic        if_grant;
  logic        resp_active;
  logic [63:0] word_idx;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A request is only accepted in IDLE and never while reset is asserted, so
  // a reset cycle can not silently swallow a handshake.
  assign in_idle  = (state_q == ST_IDLE) && !rst;

  // D wins unless IF is also waiting and has been denied MAX_WAIT times in a row.
  assign d_grant  = in_idle && bus.d_req_valid &&
                    !(bus.if_req_valid && (wait_cnt_q == MAX_WAIT_C));
  assign if_grant = in_idle && bus.if_req_valid && !d_grant;

  assign bus.d_req_ready  = d_grant;
  assign bus.if_req_ready = if_grant;

  // The response is suppressed in a reset cycle: reset drops the transaction.
  assign resp_active = (state_q == ST_RESP) && !rst;

  // Byte address -> 64-bit word index, plain unsigned wrap-around arithmetic.
  assign word_idx = (addr_q - MEM_BASE) >> 3;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through the
  // case statement leaves it unassigned and a latch can not be inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (d_grant) begin
          state_d = ST_ISSUE;
          owner_d = OWN_D;
          addr_d  = bus.d_req_addr;
          wen_d   = bus.d_req_wen;
          wdata_d = bus.d_req_wdata;
          wmask_d = bus.d_req_wmask;
        end else if (if_grant) begin
          state_d = ST_ISSUE;
          owner_d = OWN_IF;
          addr_d  = bus.if_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
        end

        // Count IF denials caused by a D grant; forget them as soon as IF is
        // served or stops asking.
        if (if_grant || !bus.if_req_valid) begin
          wait_cnt_d = '0;
        end else if (d_grant && (wait_cnt_q != MAX_WAIT_C)) begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end

      ST_ISSUE: state_d = ST_RESP;

      ST_RESP:  state_d = ST_IDLE;

      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port and response outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_en        = 1'b0;
    bus.mem_ridx      = '0;
    bus.mem_widx      = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_wdata     = '0;
    bus.mem_wmask     = '0;
    bus.if_resp_valid = 1'b0;
    bus.if_resp_inst  = '0;
    bus.d_resp_valid  = 1'b0;
    bus.d_resp_rdata  = '0;

    // The issue strobe is deliberately not gated by reset: a write launched in
    // this cycle still lands in memory.
    if (state_q == ST_ISSUE) begin
      bus.mem_en   = 1'b1;
      bus.mem_ridx = word_idx;
      bus.mem_widx = word_idx;
      bus.mem_wen  = wen_q;
      if (wen_q) begin
        bus.mem_wdata = wdata_q;
        bus.mem_wmask = wmask_q;
      end
    end

    if (resp_active) begin
      if (owner_q == OWN_IF) begin
        bus.if_resp_valid = 1'b1;
        // Instructions are 4 bytes: address bit 2 picks the half of the word.
        bus.if_resp_inst  = addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      end else begin
        bus.d_resp_valid = 1'b1;
        bus.d_resp_rdata = wen_q ? 64'h0 : bus.mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register. The latched request
  // fields are reset too, so no stale data can reach the memory port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.if_req_ready && bus.d_req_ready));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
    (bus.if_req_ready || bus.d_req_ready) |-> (state_q == ST_IDLE));

  a_wait_saturates: assert property (@(posedge clk) disable iff (rst)
    wait_cnt_q <= MAX_WAIT_C);

  a_single_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.if_resp_valid && bus.d_resp_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Drives the arbiter with directed and random IF/D traffic against a small
//   RAM. A transaction-level model predicts every output each cycle from the
//   arbitration rules and the cycle count since the last acceptance.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam logic [63:0] MEM_BASE = 64'h8000_0000;
  localparam int          MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_BASE (MEM_BASE),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory environment: 64 words, registered read, masked write.
  // ---------------------------------------------------------------------------
  logic [63:0] ram    [64];
  logic [63:0] shadow [64];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= ram[bus.mem_ridx[5:0]];
      if (bus.mem_wen)
        ram[bus.mem_widx[5:0]] <= (ram[bus.mem_widx[5:0]] & ~bus.mem_wmask) |
                                  (bus.mem_wdata & bus.mem_wmask);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: one accepted transaction, identified by the cycle it was
  // accepted in. One cycle later it hits memory, two cycles later it answers.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_d;
    logic [63:0] addr;
    bit          wen;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [63:0] rd;
  } txn_t;

  txn_t cur;
  bit   have_txn = 0;
  int   acc_cyc  = 0;
  int   cyc      = 0;
  int   denials  = 0;

  task automatic model_cycle();
    int          age;
    logic        e_if_rdy, e_d_rdy, e_if_rv, e_d_rv, e_en, e_wen;
    logic [31:0] e_inst;
    logic [63:0] e_rdata, e_idx, e_wd, e_wm;
    bit          gd, gi;

    age = have_txn ? (cyc - acc_cyc) : 3;
    e_if_rdy = 0; e_d_rdy = 0; e_if_rv = 0; e_d_rv = 0; e_en = 0; e_wen = 0;
    e_inst = '0; e_rdata = '0; e_idx = '0; e_wd = '0; e_wm = '0;

    if (age == 1) begin
      e_en  = 1;
      e_idx = (cur.addr - MEM_BASE) >> 3;
      e_wen = cur.wen;
      if (cur.wen) begin
        e_wd = cur.wdata;
        e_wm = cur.wmask;
      end
      cur.rd = shadow[e_idx[5:0]];
      if (cur.wen)
        shadow[e_idx[5:0]] = (shadow[e_idx[5:0]] & ~cur.wmask) | (cur.wdata & cur.wmask);
    end

    if (age == 2 && !rst) begin
      if (cur.is_d) begin
        e_d_rv  = 1;
        e_rdata = cur.wen ? 64'h0 : cur.rd;
      end else begin
        e_if_rv = 1;
        e_inst  = cur.addr[2] ? cur.rd[63:32] : cur.rd[31:0];
      end
    end

    if (rst) begin
      have_txn = 0;
      denials  = 0;
    end else if (age >= 3) begin
      gd = bus.d_req_valid && !(bus.if_req_valid && denials == MAX_WAIT);
      gi = bus.if_req_valid && !gd;
      e_d_rdy  = gd;
      e_if_rdy = gi;
      if (gd && bus.if_req_valid && denials < MAX_WAIT) denials++;
      if (gi || !bus.if_req_valid) denials = 0;
      if (gd || gi) begin
        have_txn  = 1;
        acc_cyc   = cyc;
        cur.is_d  = gd;
        cur.addr  = gd ? bus.d_req_addr : bus.if_req_addr;
        cur.wen   = gd && bus.d_req_wen;
        cur.wdata = bus.d_req_wdata;
        cur.wmask = bus.d_req_wmask;
      end
    end

    check("if_req_ready",  64'(bus.if_req_ready),  64'(e_if_rdy));
    check("d_req_ready",   64'(bus.d_req_ready),   64'(e_d_rdy));
    check("if_resp_valid", 64'(bus.if_resp_valid), 64'(e_if_rv));
    check("if_resp_inst",  64'(bus.if_resp_inst),  64'(e_inst));
    check("d_resp_valid",  64'(bus.d_resp_valid),  64'(e_d_rv));
    check("d_resp_rdata",  bus.d_resp_rdata,       e_rdata);
    check("mem_en",        64'(bus.mem_en),        64'(e_en));
    check("mem_ridx",      bus.mem_ridx,           e_idx);
    check("mem_widx",      bus.mem_widx,           e_idx);
    check("mem_wen",       64'(bus.mem_wen),       64'(e_wen));
    check("mem_wdata",     bus.mem_wdata,          e_wd);
    check("mem_wmask",     bus.mem_wmask,          e_wm);
  endtask

  // Compare process: every cycle after the first clock edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_cycle();
      cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    bus.if_req_valid = 0;
    bus.if_req_addr  = '0;
    bus.d_req_valid  = 0;
    bus.d_req_addr   = '0;
    bus.d_req_wen    = 0;
    bus.d_req_wdata  = '0;
    bus.d_req_wmask  = '0;
  endtask

  // One request from start to response; captures what the DUT showed in the
  // ISSUE and RESP cycles for literal checks by the caller.
  task automatic xact(input bit is_d, input logic [63:0] addr, input bit wen,
                      input logic [63:0] wdata, input logic [63:0] wmask,
                      output logic men, output logic [63:0] idx, output logic mwen,
                      output logic rvalid, output logic [63:0] rdata);
    int   waited;
    logic rdy;
    waited = 0;
    if (is_d) begin
      bus.d_req_valid = 1; bus.d_req_addr = addr; bus.d_req_wen = wen;
      bus.d_req_wdata = wdata; bus.d_req_wmask = wmask;
    end else begin
      bus.if_req_valid = 1; bus.if_req_addr = addr;
    end
    @(negedge clk);
    rdy = is_d ? bus.d_req_ready : bus.if_req_ready;
    while (!rdy && waited < 20) begin
      @(negedge clk);
      waited++;
      rdy = is_d ? bus.d_req_ready : bus.if_req_ready;
    end
    check("xact_accept", 64'(rdy), 64'(1));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    men  = bus.mem_en;
    idx  = wen ? bus.mem_widx : bus.mem_ridx;
    mwen = bus.mem_wen;
    @(negedge clk);
    rvalid = is_d ? bus.d_resp_valid : bus.if_resp_valid;
    rdata  = is_d ? bus.d_resp_rdata : {32'h0, bus.if_resp_inst};
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic        men, mwen, rv;
    logic [63:0] idx, rd;
    int          grants, last_c;
    bit          want_if;
    logic [63:0] w;

    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      w = {$urandom, $urandom};
      ram[i]    = w;
      shadow[i] = w;
    end
    ram[0]    = 64'h1111_2222_3333_4444;
    shadow[0] = 64'h1111_2222_3333_4444;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_if_ready",  64'(bus.if_req_ready), 64'(0));
    check("rst_mem_en",    64'(bus.mem_en),       64'(0));
    check("rst_d_resp",    64'(bus.d_resp_valid), 64'(0));
    rst = 0;
    repeat (2) begin @(posedge clk); #1; end

    // 1: single IF read of the upper half of word 0
    xact(0, MEM_BASE + 64'd4, 0, '0, '0, men, idx, mwen, rv, rd);
    check("t1_mem_en", 64'(men), 64'(1));
    check("t1_ridx",   idx,      64'd0);
    check("t1_valid",  64'(rv),  64'(1));
    check("t1_inst",   rd,       64'h0000_0000_1111_2222);

    // 2: D write then read-back of word 1
    xact(1, MEM_BASE + 64'd8, 1, 64'hDEAD_BEEF_0000_0001, '1, men, idx, mwen, rv, rd);
    check("t2_wen",    64'(mwen), 64'(1));
    check("t2_widx",   idx,       64'd1);
    check("t2_wvalid", 64'(rv),   64'(1));
    check("t2_wrdata", rd,        64'h0);
    xact(1, MEM_BASE + 64'd8, 0, '0, '0, men, idx, mwen, rv, rd);
    check("t2_rvalid", 64'(rv),   64'(1));
    check("t2_rdata",  rd,        64'hDEAD_BEEF_0000_0001);

    // 3/4/6: both requesters always valid -> D,D,D,D,IF repeating, 3 cycles apart
    bus.if_req_valid = 1; bus.if_req_addr = MEM_BASE + 64'd16;
    bus.d_req_valid  = 1; bus.d_req_addr  = MEM_BASE + 64'd24; bus.d_req_wen = 0;
    grants = 0; last_c = -1;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      @(negedge clk);
      if (bus.if_req_ready || bus.d_req_ready) begin
        want_if = (grants % 5) == 4;
        check("t3_grant_if", 64'(bus.if_req_ready), 64'(want_if));
        check("t3_grant_d",  64'(bus.d_req_ready),  64'(!want_if));
        if (last_c >= 0) check("t6_spacing", 64'(c - last_c), 64'd3);
        last_c = c;
        grants++;
      end
    end
    check("t3_grant_count", 64'(grants), 64'd10);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) begin @(posedge clk); #1; end

    // 5: reset during ISSUE of an IF read drops it; next request accepted at once
    bus.if_req_valid = 1; bus.if_req_addr = MEM_BASE + 64'd32;
    @(negedge clk);
    check("t5_if_accept", 64'(bus.if_req_ready), 64'(1));
    @(posedge clk); #1;
    bus.if_req_valid = 0;
    rst = 1;
    @(negedge clk);
    check("t5_issue_en", 64'(bus.mem_en), 64'(1));
    @(posedge clk); #1;
    rst = 0;
    bus.d_req_valid = 1; bus.d_req_addr = MEM_BASE + 64'd40; bus.d_req_wen = 0;
    @(negedge clk);
    check("t5_no_if_resp", 64'(bus.if_resp_valid), 64'(0));
    check("t5_d_accept",   64'(bus.d_req_ready),   64'(1));
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) begin @(posedge clk); #1; end

    // Random traffic, occasional reset and below-base (wrapping) addresses
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.if_req_valid = ($urandom_range(0, 3) != 0);
      bus.if_req_addr  = ($urandom_range(0, 15) == 0) ? (MEM_BASE - 64'd8) :
                         MEM_BASE + (64'($urandom_range(0, 63)) << 3) + (64'($urandom_range(0, 1)) << 2);
      bus.d_req_valid  = ($urandom_range(0, 2) != 0);
      bus.d_req_addr   = ($urandom_range(0, 15) == 0) ? (MEM_BASE - 64'd8) :
                         MEM_BASE + (64'($urandom_range(0, 63)) << 3);
      bus.d_req_wen    = $urandom_range(0, 1);
      bus.d_req_wdata  = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       bus.d_req_wmask = '1;
        1:       bus.d_req_wmask = 64'h0000_0000_FFFF_FFFF;
        default: bus.d_req_wmask = {$urandom, $urandom};
      endcase
      @(posedge clk); #1;
    end
    rst = 0;
    idle_inputs();
    repeat (4) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
